// File: rtl/hx711_pkg.sv
// Shared types for the HX711 measurement sequencer: FSM states, gain codes, 24-bit saturation.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package hx711_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_FINISH,
    ST_ERROR
  } state_t;

  // Extra PD_SCK pulse count after each conversion selects channel and gain.
  localparam logic [1:0] GAIN_A128 = 2'd1;
  localparam logic [1:0] GAIN_B32  = 2'd2;
  localparam logic [1:0] GAIN_A64  = 2'd3;

  // Clamp a 25-bit signed difference into the 24-bit signed range.
  function automatic logic [23:0] sat24(input logic signed [24:0] d);
    if (d[24] != d[23]) begin
      return d[24] ? 24'h800000 : 24'h7FFFFF;
    end
    return d[23:0];
  endfunction

endpackage

// File: rtl/hx711_timeout.sv
// Reloadable cycle counter that flags when no sample has arrived for TIMEOUT_CYC cycles.
// Latency: expired_o is combinational from the counter register; clear takes effect next cycle.
// Backpressure: none; counts only while en_i is high.
// Ports: clk_i/rst_i clock and sync reset; clr_i restarts the count; en_i enables counting;
//        expired_o high while enabled and TIMEOUT_CYC cycles have elapsed since the last clear.
module hx711_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter starts at 0 in the first cycle after a clear, so reaching
  // TIMEOUT_CYC-1 means TIMEOUT_CYC full cycles have gone by.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hx711_meas_ctrl.sv
// HX711 measurement sequencer: gain select, settle discard, 2^AVG_LOG2 averaging, tare, saturation.
// Latency: start->rx_en 1 cycle; last accumulated sample->result_valid 2 cycles.
// Backpressure: none; start/tare while busy are dropped, samples outside SETTLE/ACCUM ignored.
// Ports: start_i/tare_i op pulses, gain_req_i gain code (0 -> 1), s_valid_i/sample_i receiver word;
//        rx_en_o/extra_pulses_o receiver control, result_o/result_valid_o measurement,
//        tare_done_o offset update strobe, busy_o non-idle, err_timeout_o sticky timeout flag.
module hx711_meas_ctrl
  import hx711_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int DISCARD     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        tare_i,
  input  logic [1:0]  gain_req_i,
  input  logic        s_valid_i,
  input  logic [23:0] sample_i,
  output logic        rx_en_o,
  output logic [1:0]  extra_pulses_o,
  output logic [23:0] result_o,
  output logic        result_valid_o,
  output logic        tare_done_o,
  output logic        busy_o,
  output logic        err_timeout_o
);

  localparam int ACC_W = 24 + AVG_LOG2;
  localparam int NS    = 1 << AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int DW    = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

  state_t                    state_q, state_d;
  logic                      tare_op_q, tare_op_d;
  logic                      first_q, first_d;
  logic [1:0]                gain_q, gain_d;
  logic [DW-1:0]             disc_q, disc_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          nsamp_q, nsamp_d;
  logic [23:0]               offset_q, offset_d;
  logic [23:0]               result_q, result_d;
  logic                      rv_q, rv_d;
  logic                      td_q, td_d;
  logic                      err_q, err_d;
  logic                      rx_en_q, rx_en_d;
  logic                      busy_q, busy_d;

  logic                      tmo_clr, tmo_en, tmo_exp;
  logic [1:0]                gain_sel;
  logic [23:0]               avg;
  logic signed [24:0]        diff;

  assign tmo_en = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);

  hx711_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    tare_op_d = tare_op_q;
    first_d   = first_q;
    gain_d    = gain_q;
    disc_d    = disc_q;
    acc_d     = acc_q;
    nsamp_d   = nsamp_q;
    offset_d  = offset_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    td_d      = 1'b0;
    err_d     = err_q;
    tmo_clr   = 1'b0;

    gain_sel = (gain_req_i == 2'd0) ? GAIN_A128 : gain_req_i;
    // Arithmetic shift floors toward -inf, which is the intended rounding.
    avg  = 24'(acc_q >>> AVG_LOG2);
    diff = $signed({avg[23], avg}) - $signed({offset_q[23], offset_q});

    case (state_q)
      ST_IDLE: begin
        if (start_i || tare_i) begin
          tare_op_d = tare_i;
          gain_d    = gain_sel;
          first_d   = 1'b0;
          err_d     = 1'b0;
          tmo_clr   = 1'b1;
          // The first conversion after a gain change uses the previous gain setting.
          if ((DISCARD > 0) && (first_q || (gain_sel != gain_q))) begin
            state_d = ST_SETTLE;
            disc_d  = DW'(DISCARD);
          end else begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            nsamp_d = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (s_valid_i) begin
          tmo_clr = 1'b1;
          if (disc_q == DW'(1)) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            nsamp_d = '0;
          end else begin
            disc_d = disc_q - DW'(1);
          end
        end else if (tmo_exp) begin
          state_d = ST_ERROR;
        end
      end
      ST_ACCUM: begin
        if (s_valid_i) begin
          tmo_clr = 1'b1;
          acc_d   = acc_q + ACC_W'(signed'(sample_i));
          if (nsamp_q == CNT_W'(NS - 1)) begin
            state_d = ST_FINISH;
          end else begin
            nsamp_d = nsamp_q + CNT_W'(1);
          end
        end else if (tmo_exp) begin
          state_d = ST_ERROR;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (tare_op_q) begin
          offset_d = avg;
          td_d     = 1'b1;
        end else begin
          result_d = sat24(diff);
          rv_d     = 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs follow the next state so they line up with the state change.
    rx_en_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_ERROR) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tare_op_q <= 1'b0;
      first_q   <= 1'b1;
      gain_q    <= GAIN_A128;
      disc_q    <= '0;
      acc_q     <= '0;
      nsamp_q   <= '0;
      offset_q  <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      td_q      <= 1'b0;
      err_q     <= 1'b0;
      rx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tare_op_q <= tare_op_d;
      first_q   <= first_d;
      gain_q    <= gain_d;
      disc_q    <= disc_d;
      acc_q     <= acc_d;
      nsamp_q   <= nsamp_d;
      offset_q  <= offset_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      td_q      <= td_d;
      err_q     <= err_d;
      rx_en_q   <= rx_en_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_en_o        = rx_en_q;
  assign extra_pulses_o = gain_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign tare_done_o    = td_q;
  assign busy_o         = busy_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_hx711_meas_ctrl.sv
// Directed bench for hx711_meas_ctrl with an expected-result queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_hx711_meas_ctrl;

  localparam int AVG_LOG2 = 2;
  localparam int TMO      = 50;
  localparam int DISCARD  = 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        tare_i = 1'b0;
  logic [1:0]  gain_req_i = 2'd1;
  logic        s_valid_i = 1'b0;
  logic [23:0] sample_i = '0;
  logic        rx_en_o;
  logic [1:0]  extra_pulses_o;
  logic [23:0] result_o;
  logic        result_valid_o;
  logic        tare_done_o;
  logic        busy_o;
  logic        err_timeout_o;

  int          total = 0;
  int          bad = 0;
  int          rv_cnt = 0;
  logic [31:0] sb[$];
  longint      offset_m = 0;

  always #5 clk = ~clk;

  hx711_meas_ctrl #(
    .AVG_LOG2    (AVG_LOG2),
    .TIMEOUT_CYC (TMO),
    .DISCARD     (DISCARD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .tare_i         (tare_i),
    .gain_req_i     (gain_req_i),
    .s_valid_i      (s_valid_i),
    .sample_i       (sample_i),
    .rx_en_o        (rx_en_o),
    .extra_pulses_o (extra_pulses_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .tare_done_o    (tare_done_o),
    .busy_o         (busy_o),
    .err_timeout_o  (err_timeout_o)
  );

  always @(negedge clk) begin
    if (result_valid_o === 1'b1) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: floor average of the summed samples minus the tare offset, clamped to 24 bits.
  function automatic logic [31:0] model(input longint sum);
    longint avg, d;
    avg = sum >>> AVG_LOG2;
    d   = avg - offset_m;
    if (d > 64'sd8388607)  d = 64'sd8388607;
    if (d < -64'sd8388608) d = -64'sd8388608;
    return {8'h00, d[23:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic is_tare, input logic [1:0] g);
    start_i    = !is_tare;
    tare_i     = is_tare;
    gain_req_i = g;
    tick();
    start_i = 1'b0;
    tare_i  = 1'b0;
  endtask

  task automatic smp(input int v);
    s_valid_i = 1'b1;
    sample_i  = v[23:0];
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic smp4(input int v);
    for (int i = 0; i < 4; i++) smp(v);
  endtask

  task automatic wait_result(input string tag);
    bit          got;
    int          lat;
    logic [31:0] expv;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (result_valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      expv = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
      check({tag, ".val"}, {8'h00, result_o}, expv);
      check({tag, ".lat"}, lat, 32'd2);
      check({tag, ".busy"}, {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      check({tag, ".pulse"}, {31'd0, result_valid_o}, 32'd0);
    end
  endtask

  task automatic wait_tare(input string tag, input logic [23:0] prev);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tare_done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, ".res_hold"}, {8'h00, result_o}, {8'h00, prev});
      check({tag, ".rv"}, {31'd0, result_valid_o}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_en"}, {31'd0, rx_en_o}, 32'd0);
    check({tag, ".xp"}, {30'd0, extra_pulses_o}, 32'd1);
    check({tag, ".result"}, {8'h00, result_o}, 32'd0);
    check({tag, ".rv"}, {31'd0, result_valid_o}, 32'd0);
    check({tag, ".td"}, {31'd0, tare_done_o}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, ".err"}, {31'd0, err_timeout_o}, 32'd0);
  endtask

  initial begin
    int  rv0;
    bit  got;

    // Reset values
    rst_i = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_i = 1'b0;
    tick();

    // First op after reset: one settling sample discarded, then 100..400
    op(1'b0, 2'd1);
    check("m1.rx_en", {31'd0, rx_en_o}, 32'd1);
    check("m1.busy", {31'd0, busy_o}, 32'd1);
    sb.push_back(model(64'sd1000));
    smp(999);
    smp(100); smp(200); smp(300); smp(400);
    wait_result("m1");
    check("m1.xp", {30'd0, extra_pulses_o}, 32'd1);

    // Tare to 1000, then a same-gain measurement with no settle
    op(1'b1, 2'd1);
    smp4(1000);
    wait_tare("t1", 24'd250);
    offset_m = 1000;
    op(1'b0, 2'd1);
    sb.push_back(model(64'sd5000));
    smp4(1250);
    wait_result("m2");

    // Gain change to 2 plus negative saturation
    op(1'b0, 2'd2);
    check("g2.xp", {30'd0, extra_pulses_o}, 32'd2);
    sb.push_back(model(-64'sd33554432));
    smp(5);
    smp4(-8388608);
    wait_result("negsat");

    // Positive saturation with offset -1000
    op(1'b1, 2'd2);
    smp4(-1000);
    wait_tare("t2", 24'h800000);
    offset_m = -1000;
    op(1'b0, 2'd2);
    sb.push_back(model(64'sd33554428));
    smp4(8388607);
    wait_result("possat");

    // Floor of a negative average with zero offset
    op(1'b1, 2'd2);
    smp4(0);
    wait_tare("t3", 24'h7FFFFF);
    offset_m = 0;
    op(1'b0, 2'd2);
    sb.push_back(model(-64'sd7));
    smp(-1); smp(-2); smp(-2); smp(-2);
    wait_result("floor");

    // Timeout with no samples
    rv0 = rv_cnt;
    op(1'b0, 2'd2);
    got = 1'b0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      if (err_timeout_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("tmo.seen", {31'd0, got}, 32'd1);
    check("tmo.rx_en", {31'd0, rx_en_o}, 32'd0);
    @(negedge clk);
    check("tmo.idle", {31'd0, busy_o}, 32'd0);
    check("tmo.err_sticky", {31'd0, err_timeout_o}, 32'd1);
    check("tmo.no_result", rv_cnt, rv0);
    op(1'b0, 2'd2);
    check("tmo.err_clr", {31'd0, err_timeout_o}, 32'd0);
    check("tmo.rx_en2", {31'd0, rx_en_o}, 32'd1);
    sb.push_back(model(64'sd100));
    smp(10); smp(20); smp(30); smp(40);
    wait_result("after_tmo");

    // start while busy is dropped; samples in IDLE are ignored
    op(1'b0, 2'd2);
    sb.push_back(model(64'sd10));
    smp(1); smp(2);
    op(1'b0, 2'd2);
    rv0 = rv_cnt;
    smp(3); smp(4);
    wait_result("busy_ign");
    smp4(100);
    repeat (10) tick();
    check("busy_ign.count", rv_cnt, rv0 + 1);

    // Reset mid-ACCUM clears outputs, offset and forces a settle again
    op(1'b1, 2'd2);
    smp4(500);
    wait_tare("t4", 24'd2);
    offset_m = 500;
    op(1'b0, 2'd2);
    smp(1); smp(2);
    rst_i = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    offset_m = 0;
    tick();
    op(1'b0, 2'd1);
    sb.push_back(model(64'sd160));
    smp(7);
    smp4(40);
    wait_result("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hx711_meas_ctrl.md
# hx711_meas_ctrl

Measurement sequencer placed between the HX711 serial receiver and the display/consumer logic. It enables the receiver and selects gain/channel through the extra-pulse count. After every gain change it discards the settling conversion, then averages 2^AVG_LOG2 samples and subtracts a stored tare offset. It delivers a saturated signed 24-bit result with a valid strobe and supervises the converter with a timeout.

## Interface
- AVG_LOG2, 2: log2 of samples averaged per result (0..4).
- TIMEOUT_CYC, 1_000_000: max clk cycles waited for one sample before error.
- DISCARD, 1: conversions dropped after gain change or start.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin one averaged measurement.
- tare  in  1  one-cycle pulse; run measurement and store average as offset.
- gain_req  in  2  1=ChA/128, 2=ChB/32, 3=ChA/64; 0 is illegal and treated as 1.
- s_valid  in  1  one-cycle strobe from receiver: sample_in is new.
- sample_in  in  24  two's-complement conversion word.
- rx_en  out  1  enables the receiver/PD_SCK generation.
- extra_pulses  out  2  gain code driven to the receiver.
- result  out  24  signed (average − tare), saturated.
- result_valid  out  1  one-cycle strobe with result.
- tare_done  out  1  one-cycle strobe when the offset is updated.
- busy  out  1  high in any state except IDLE.
- err_timeout  out  1  sticky; cleared by the next accepted start/tare.

## Operation
- States: IDLE, SETTLE, ACCUM, FINISH, ERROR.
- IDLE: rx_en=0. start or tare → latch op (tare wins if both asserted) and gain_req (0 mapped to 1). If the latched gain differs from extra_pulses, or this is the first op since reset → SETTLE with discard count DISCARD. Otherwise → ACCUM. extra_pulses updates on the same edge.
- SETTLE: rx_en=1. Each s_valid decrements the discard count, and its sample is ignored. When the count reaches 0 → ACCUM. DISCARD=0 skips SETTLE.
- ACCUM: rx_en=1. Each s_valid adds sign-extended sample_in into a (24+AVG_LOG2)-bit accumulator. After 2^AVG_LOG2 samples → FINISH.
- FINISH (1 cycle): avg = acc >>> AVG_LOG2 (arithmetic shift, floor).
  - measure: diff = avg − offset computed at 25 bits. result = diff clamped to [−2^23, 2^23−1]. result_valid=1.
  - tare: offset←avg, tare_done=1; result is unchanged.
  - Then → IDLE.
- Timeout: a cycle counter clears on entry to SETTLE/ACCUM and on every s_valid. When it reaches TIMEOUT_CYC → ERROR. ERROR sets err_timeout, drops rx_en, discards the accumulator, leaves offset untouched, and returns to IDLE the next cycle.
- start/tare while busy: ignored. There is no queueing.
- s_valid in IDLE/FINISH/ERROR: ignored.

## Timing
- Reset values: rx_en=0, extra_pulses=1, result=0, offset=0, result_valid=0, tare_done=0, busy=0, err_timeout=0. The state goes to IDLE and the first-op flag is set.
- start→rx_en high: 1 cycle. busy rises on the same edge.
- Last ACCUM s_valid → result_valid: 2 cycles (ACCUM→FINISH edge, then strobe registered out of FINISH). busy falls on the same edge as the result_valid strobe.
- The accumulator clears on ACCUM entry, never on the last add.
- All outputs are registered. No combinational input→output paths.
- rst mid-operation aborts everything in one cycle. offset returns to 0.

## Structure
- Package hx711_pkg: state enum; gain codes GAIN_A128=1, GAIN_B32=2, GAIN_A64=3; function sat24(signed 25-bit) → 24-bit.
- One sub-module, hx711_timeout, which holds the reloadable cycle counter with clear and expiry output.
- Accumulator, offset register and FSM stay in the top.

## Test plan
- Reset, then start with gain 1 and samples 100, 100(discarded first: 999), 200, 300, 400, AVG_LOG2=2. Result is 250, result_valid one cycle, extra_pulses=1.
- tare with four samples of 1000 → tare_done. Then start with samples 1250 ×4 → result 250, no SETTLE (same gain).
- Change gain_req to 2 → extra_pulses=2, first sample discarded. Averages −8,388,608 ×4 with offset 1000 → result saturates to −8,388,608 (0x800000).
- Positive saturation: offset −1000, samples 0x7FFFFF → result 0x7FFFFF. Negative averages check floor: samples −1,−2,−2,−2 → −2.
- No s_valid for TIMEOUT_CYC cycles in ACCUM → err_timeout=1, rx_en=0, state IDLE. The next start clears err_timeout.
- start during busy is ignored (no second result). rst asserted mid-ACCUM → all outputs at reset values the next cycle, offset=0.
